// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared opcodes, FSM states and flag indices for the sequential ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLT   = 4'h5;
  localparam logic [3:0] OP_SLTU  = 4'h6;
  localparam logic [3:0] OP_SLL   = 4'h7;
  localparam logic [3:0] OP_SRL   = 4'h8;
  localparam logic [3:0] OP_SRA   = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'hA;
  localparam logic [3:0] OP_MULHU = 4'hB;
  localparam logic [3:0] OP_DIV   = 4'hC;
  localparam logic [3:0] OP_DIVU  = 4'hD;
  localparam logic [3:0] OP_REM   = 4'hE;
  localparam logic [3:0] OP_REMU  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int F_Z = 0;
  localparam int F_N = 1;
  localparam int F_C = 2;
  localparam int F_V = 3;

  // Everything from MUL upwards runs on the iterative datapath.
  function automatic logic isIterOp(input logic [3:0] op);
    return op >= OP_MUL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ============================================================================
// Module  : alu_muldiv_iter
// Brief   : One-bit-per-cycle shift-add multiplier / restoring divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_origA;
  logic [3:0]         r_op;
  logic               r_negQ;
  logic               r_negR;
  logic               r_divZero;

  logic               w_signed;
  logic               w_startMul;
  logic               w_isMul;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_accNext;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_signed   = (op == OP_DIV) || (op == OP_REM);
  assign w_startMul = (op == OP_MUL) || (op == OP_MULHU);
  assign w_magA     = (w_signed && opA[WIDTH-1]) ? -opA : opA;
  assign w_magB     = (w_signed && opB[WIDTH-1]) ? -opB : opB;
  assign w_isMul    = (r_op == OP_MUL) || (r_op == OP_MULHU);

  // r_acc is {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    w_addend  = r_acc[0] ? r_mcand : '0;
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_trial   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_mcand};
    w_accNext = '0;
    if (w_isMul) begin
      w_accNext = {w_sum, r_acc[WIDTH-1:1]};
    end else if (!w_trial[WIDTH]) begin
      w_accNext = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_accNext = {r_acc[2*WIDTH-2:0], 1'b0};
    end
  end

  // The result is taken from the final step directly so the owner can latch it on done.
  always_comb begin
    w_quo  = w_accNext[WIDTH-1:0];
    w_rem  = w_accNext[2*WIDTH-1:WIDTH];
    result = '0;
    case (r_op)
      OP_MUL:           result = w_accNext[WIDTH-1:0];
      OP_MULHU:         result = w_accNext[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:  result = r_divZero ? '1 : (r_negQ ? -w_quo : w_quo);
      default:          result = r_divZero ? r_origA : (r_negR ? -w_rem : w_rem);
    endcase
  end

  assign done = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_origA   <= '0;
      r_op      <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
    end else if (start) begin
      r_cnt     <= CNT_W'(WIDTH);
      r_op      <= op;
      r_origA   <= opA;
      r_divZero <= (opB == '0);
      r_negQ    <= w_signed && (opA[WIDTH-1] ^ opB[WIDTH-1]);
      r_negR    <= w_signed && opA[WIDTH-1];
      if (w_startMul) begin
        r_acc   <= {{WIDTH{1'b0}}, opB};
        r_mcand <= opA;
      end else begin
        r_acc   <= {{WIDTH{1'b0}}, w_magA};
        r_mcand <= w_magB;
      end
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_acc <= w_accNext;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module  : alu_seq
// Brief   : Handshaked RV32IM ALU: single-cycle base ops, iterative mul/div.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] scrA,
  input  logic [WIDTH-1:0] scrB,
  input  logic [3:0]       AluControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUresult,
  output logic [3:0]       Flag,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_stateNext;
  logic             w_accept;
  logic             w_startIter;
  logic             w_iterDone;
  logic [WIDTH-1:0] w_iterResult;
  logic [WIDTH-1:0] w_fastResult;
  logic             w_fastC;
  logic             w_fastV;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_shamt;

  assign w_accept    = in_valid && in_ready;
  assign w_startIter = w_accept && isIterOp(AluControl);
  assign w_sum       = {1'b0, scrA} + {1'b0, scrB};
  assign w_diff      = {1'b0, scrA} - {1'b0, scrB};
  assign w_shamt     = scrB[SHW-1:0];

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_startIter),
    .op     (AluControl),
    .opA    (scrA),
    .opB    (scrB),
    .done   (w_iterDone),
    .result (w_iterResult)
  );

  always_comb begin
    w_fastResult = w_sum[WIDTH-1:0];
    w_fastC      = 1'b0;
    w_fastV      = 1'b0;
    case (AluControl)
      OP_ADD: begin
        w_fastResult = w_sum[WIDTH-1:0];
        w_fastC      = w_sum[WIDTH];
        w_fastV      = (scrA[WIDTH-1] == scrB[WIDTH-1]) && (w_sum[WIDTH-1] != scrA[WIDTH-1]);
      end
      OP_SUB: begin
        w_fastResult = w_diff[WIDTH-1:0];
        w_fastC      = ~w_diff[WIDTH];
        w_fastV      = (scrA[WIDTH-1] != scrB[WIDTH-1]) && (w_diff[WIDTH-1] != scrA[WIDTH-1]);
      end
      OP_AND:  w_fastResult = scrA & scrB;
      OP_OR:   w_fastResult = scrA | scrB;
      OP_XOR:  w_fastResult = scrA ^ scrB;
      OP_SLT:  w_fastResult = {{(WIDTH-1){1'b0}}, ($signed(scrA) < $signed(scrB))};
      OP_SLTU: w_fastResult = {{(WIDTH-1){1'b0}}, (scrA < scrB)};
      OP_SLL:  w_fastResult = scrA << w_shamt;
      OP_SRL:  w_fastResult = scrA >> w_shamt;
      OP_SRA:  w_fastResult = $signed(scrA) >>> w_shamt;
      default: w_fastResult = w_sum[WIDTH-1:0];
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_stateNext = isIterOp(AluControl) ? S_ITER : S_DONE;
        end
      end
      S_ITER: begin
        if (w_iterDone) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Output registers only change on acceptance of a fast op or on iterative completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      ALUresult <= '0;
      Flag      <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept && !w_startIter) begin
        ALUresult <= w_fastResult;
        Flag[F_Z] <= (w_fastResult == '0);
        Flag[F_N] <= w_fastResult[WIDTH-1];
        Flag[F_C] <= w_fastC;
        Flag[F_V] <= w_fastV;
      end else if ((r_state == S_ITER) && w_iterDone) begin
        ALUresult <= w_iterResult;
        Flag[F_Z] <= (w_iterResult == '0);
        Flag[F_N] <= w_iterResult[WIDTH-1];
        Flag[F_C] <= 1'b0;
        Flag[F_V] <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
